// File: rtl/bec_ladder_feeder_if.sv
// Host write/read port plus core download/upload signals of the ladder feeder.
// The slave modport is the feeder itself. The master modport is the surrounding
// environment, which is the host together with the ladder core.
interface bec_ladder_feeder_if #(
  parameter int W     = 163,
  parameter int BUS_W = 32
);
  logic             wr_valid;
  logic             wr_ready;
  logic [2:0]       wr_sel;
  logic [2:0]       wr_word;
  logic [BUS_W-1:0] wr_data;
  logic             start;
  logic             busy;
  logic             err;
  logic             res_valid;
  logic [3:0]       rd_sel;
  logic [BUS_W-1:0] rd_data;
  logic             load_data;
  logic             enable;
  logic             trigLoad;
  logic [2:0]       load_status;
  logic [W-1:0]     data_in;
  logic             ki;
  logic             next_key;
  logic [3:0]       becStatus;
  logic             done;
  logic [W-1:0]     data_out;

  modport master (
    output wr_valid, wr_sel, wr_word, wr_data, start, rd_sel,
    output next_key, becStatus, done, data_out,
    input  wr_ready, busy, err, res_valid, rd_data,
    input  load_data, enable, trigLoad, load_status, data_in, ki
  );

  modport slave (
    input  wr_valid, wr_sel, wr_word, wr_data, start, rd_sel,
    input  next_key, becStatus, done, data_out,
    output wr_ready, busy, err, res_valid, rd_data,
    output load_data, enable, trigLoad, load_status, data_in, ki
  );
endinterface

// File: rtl/bec_ladder_feeder.sv
// Host-side feeder for the GF(2^163) binary-Edwards ladder core.
// It assembles the operands and the key from 32-bit host words, then downloads
// them to the core. While the core runs, it streams key bits MSB-first on ki.
// When the core finishes, it captures the X and Z results for host read-back.
module bec_ladder_feeder #(
  parameter int W      = 163,
  parameter int BUS_W  = 32,
  parameter int NWORDS = 6
) (
  input  logic                clk,
  input  logic                rst,
  bec_ladder_feeder_if.slave  bus
);
  localparam int NSLOTS = 7;
  localparam int KEY    = 6;
  localparam int PADW   = NWORDS * BUS_W;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] WAITDL = 3'd2;
  localparam logic [2:0] XFER   = 3'd3;
  localparam logic [2:0] EN     = 3'd4;
  localparam logic [2:0] RUN    = 3'd5;
  localparam logic [2:0] ULX    = 3'd6;
  localparam logic [2:0] ULZ    = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [2:0]        idx_q;
  logic              err_q;
  logic              res_valid_q;
  logic [W-1:0]      res_x_q, res_z_q;
  logic [W-1:0]      slot_q [NSLOTS];
  logic [NWORDS-1:0] mask_q [NSLOTS];
  logic [NSLOTS-1:0] slot_loaded;
  logic              all_loaded;
  logic              wr_fire;
  logic              wr_hit;

  // Overlay one bus word onto a W-bit register. Any bits of the top word that
  // lie above W-1 fall off when the padded value is truncated back to W bits.
  function automatic logic [W-1:0] put_word(input logic [W-1:0] cur,
                                            input logic [2:0] w,
                                            input logic [BUS_W-1:0] d);
    logic [PADW-1:0] ext;
    ext = PADW'(cur);
    ext[w*BUS_W +: BUS_W] = d;
    return ext[W-1:0];
  endfunction

  function automatic logic [BUS_W-1:0] get_word(input logic [W-1:0] v,
                                                input logic [2:0] w);
    logic [PADW-1:0] ext;
    ext = PADW'(v);
    return ext[w*BUS_W +: BUS_W];
  endfunction

  // A slot counts as loaded once every one of its words has been written.
  for (genvar gi = 0; gi < NSLOTS; gi++) begin : gen_loaded
    assign slot_loaded[gi] = &mask_q[gi];
  end
  assign all_loaded = &slot_loaded;

  assign wr_fire = bus.wr_valid && (state_q == IDLE);
  assign wr_hit  = wr_fire && (bus.wr_sel != 3'd7) && (32'(bus.wr_word) < NWORDS);

  // Next-state logic for the download / run / upload sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start && all_loaded) state_d = REQ;
      REQ:     state_d = WAITDL;
      WAITDL:  if (bus.becStatus[2]) state_d = XFER;
      XFER:    if (idx_q == 3'd5) state_d = EN;
      EN:      if (bus.becStatus[1]) state_d = RUN;
      RUN:     if (bus.done) state_d = ULX;
      ULX:     state_d = ULZ;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, beat counter, error pulse and the captured results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_x_q     <= '0;
      res_z_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= (state_q == XFER) ? idx_q + 3'd1 : 3'd0;
      err_q   <= (state_q == IDLE) && bus.start && !all_loaded;
      if (state_q == ULX) res_x_q <= bus.data_out;
      if (state_q == ULZ) begin
        res_z_q     <= bus.data_out;
        res_valid_q <= 1'b1;
      end else if ((state_q == IDLE) && ((bus.start && all_loaded) || bus.wr_valid)) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  // Operand/key storage: host writes in IDLE, key shifts on next_key in RUN,
  // and all loaded flags drop once a run has completed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSLOTS; i++) begin
        slot_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      if (wr_hit) begin
        slot_q[bus.wr_sel]              <= put_word(slot_q[bus.wr_sel], bus.wr_word, bus.wr_data);
        mask_q[bus.wr_sel][bus.wr_word] <= 1'b1;
      end
      if ((state_q == RUN) && bus.next_key)
        slot_q[KEY] <= {slot_q[KEY][W-2:0], 1'b0};
      if (state_q == ULZ)
        for (int i = 0; i < NSLOTS; i++) mask_q[i] <= '0;
    end
  end

  // Core-facing strobes and the operand mux. Outside the active phases, every
  // one of them is held at zero.
  always_comb begin
    bus.trigLoad    = 1'b0;
    bus.load_status = 3'd0;
    bus.data_in     = '0;
    case (state_q)
      XFER: begin
        bus.trigLoad    = 1'b1;
        bus.load_status = idx_q;
        bus.data_in     = (idx_q < 3'd6) ? slot_q[idx_q] : '0;
      end
      ULZ:     bus.load_status = 3'd1;
      default: ;
    endcase
  end

  // Host read-back: res_x words at 0..5, res_z words at 8..13, zero elsewhere.
  always_comb begin
    bus.rd_data = '0;
    if (32'(bus.rd_sel[2:0]) < NWORDS)
      bus.rd_data = get_word(bus.rd_sel[3] ? res_z_q : res_x_q, bus.rd_sel[2:0]);
  end

  assign bus.wr_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.err       = err_q;
  assign bus.res_valid = res_valid_q;
  assign bus.load_data = (state_q == REQ);
  assign bus.enable    = (state_q == EN);
  assign bus.ki        = slot_q[KEY][W-1];
endmodule

// File: tb/tb_bec_ladder_feeder.sv
// Directed bench for bec_ladder_feeder. It includes a small hand-driven
// ladder-core model. That model answers data_out from load_status once done is raised.
module tb_bec_ladder_feeder;
  localparam int W     = 163;
  localparam int BUS_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bec_ladder_feeder_if #(.W(W), .BUS_W(BUS_W)) bus ();

  bec_ladder_feeder #(.W(W), .BUS_W(BUS_W), .NWORDS(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]  pat [7][6];
  logic [W-1:0] res_x_c;
  logic [W-1:0] res_z_c;
  logic [W-1:0] exp_v;
  logic [31:0]  exp_w;
  logic         core_done;

  assign bus.done     = core_done;
  assign bus.data_out = core_done ? ((bus.load_status == 3'd1) ? res_z_c : res_x_c) : '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [2:0] s, input logic [2:0] w, input logic [31:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_sel   = s;
    bus.wr_word  = w;
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
    $display("write slot %0d word %0d data %08h", s, w, d);
  endtask

  task automatic load_slots(input int first, input int last);
    for (int s = first; s <= last; s++)
      for (int w = 0; w < 6; w++) write_word(3'(s), 3'(w), pat[s][w]);
  endtask

  task automatic clear_pat();
    for (int s = 0; s < 7; s++)
      for (int w = 0; w < 6; w++) pat[s][w] = 32'h0;
  endtask

  // Start a run and take the FSM through download and enable, ending in RUN.
  task automatic drive_to_run();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.becStatus = 4'b0100;
    tick();
    tick();
    repeat (6) tick();
    bus.becStatus = 4'b0010;
    tick();
  endtask

  // Core signals done, and the FSM uploads X then Z and returns to IDLE.
  task automatic finish_run();
    core_done = 1'b1;
    bus.becStatus = 4'b0001;
    tick();
    tick();
    tick();
    core_done = 1'b0;
    bus.becStatus = 4'b1000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_sel = '0; bus.wr_word = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.rd_sel = '0; bus.next_key = 1'b0; bus.becStatus = 4'b1000;
    core_done = 1'b0;
    res_x_c = {3'b101, {40{4'h5}}};
    res_z_c = {3'b010, {40{4'hA}}};
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_vec++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got %b want 1", bus.wr_ready); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.load_data !== 1'b0) begin n_err++; $display("FAIL reset_load_data got %b want 0", bus.load_data); end
    n_vec++; if (bus.enable !== 1'b0) begin n_err++; $display("FAIL reset_enable got %b want 0", bus.enable); end
    n_vec++; if (bus.trigLoad !== 1'b0) begin n_err++; $display("FAIL reset_trigLoad got %b want 0", bus.trigLoad); end
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", bus.err); end
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
    n_vec++; if (bus.ki !== 1'b0) begin n_err++; $display("FAIL reset_ki got %b want 0", bus.ki); end
    n_vec++; if (bus.data_in !== '0) begin n_err++; $display("FAIL reset_data_in got %h want 0", bus.data_in); end
    n_vec++; if (bus.rd_data !== '0) begin n_err++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data); end
    $display("reset checked");
  endtask

  task automatic test_err_missing_key();
    for (int s = 0; s < 7; s++)
      for (int w = 0; w < 6; w++) pat[s][w] = 32'hA000_0000 + 32'(s * 16 + w);
    load_slots(0, 5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL nokey_err got %b want 1", bus.err); end
    n_vec++; if (bus.load_data !== 1'b0) begin n_err++; $display("FAIL nokey_load_data got %b want 0", bus.load_data); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL nokey_busy got %b want 0", bus.busy); end
    tick();
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL nokey_err_pulse got %b want 0", bus.err); end
    n_vec++; if (bus.load_data !== 1'b0) begin n_err++; $display("FAIL nokey_load_data2 got %b want 0", bus.load_data); end
    $display("start without key checked");
  endtask

  task automatic test_download();
    load_slots(6, 6);
    bus.start = 1'b1;
    tick();
    n_vec++; if (bus.load_data !== 1'b1) begin n_err++; $display("FAIL dl_load_data got %b want 1", bus.load_data); end
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL dl_busy got %b want 1", bus.busy); end
    bus.becStatus = 4'b0100;
    tick();
    bus.start = 1'b0;
    n_vec++; if (bus.load_data !== 1'b0) begin n_err++; $display("FAIL dl_load_data_1cyc got %b want 0", bus.load_data); end
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL dl_busy_start_err got %b want 0", bus.err); end
    n_vec++; if (bus.trigLoad !== 1'b0) begin n_err++; $display("FAIL dl_trig_early got %b want 0", bus.trigLoad); end
    tick();
    for (int i = 0; i < 6; i++) begin
      exp_v = {pat[i][5][2:0], pat[i][4], pat[i][3], pat[i][2], pat[i][1], pat[i][0]};
      n_vec++; if (bus.trigLoad !== 1'b1) begin n_err++; $display("FAIL beat%0d_trigLoad got %b want 1", i, bus.trigLoad); end
      n_vec++; if (bus.load_status !== 3'(i)) begin n_err++; $display("FAIL beat%0d_load_status got %0d want %0d", i, bus.load_status, i); end
      n_vec++; if (bus.data_in !== exp_v) begin n_err++; $display("FAIL beat%0d_data_in got %h want %h", i, bus.data_in, exp_v); end
      n_vec++; if (bus.ki !== 1'b1) begin n_err++; $display("FAIL beat%0d_ki got %b want 1", i, bus.ki); end
      $display("beat %0d load_status %0d data_in %h", i, bus.load_status, bus.data_in);
      tick();
    end
    n_vec++; if (bus.enable !== 1'b1) begin n_err++; $display("FAIL en_enable got %b want 1", bus.enable); end
    n_vec++; if (bus.trigLoad !== 1'b0) begin n_err++; $display("FAIL en_trigLoad got %b want 0", bus.trigLoad); end
    n_vec++; if (bus.data_in !== '0) begin n_err++; $display("FAIL en_data_in got %h want 0", bus.data_in); end
    bus.becStatus = 4'b0010;
    tick();
    n_vec++; if (bus.enable !== 1'b0) begin n_err++; $display("FAIL run_enable got %b want 0", bus.enable); end
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL run_busy got %b want 1", bus.busy); end
  endtask

  task automatic test_unload();
    core_done = 1'b1;
    bus.becStatus = 4'b0001;
    tick();
    n_vec++; if (bus.load_status !== 3'd0) begin n_err++; $display("FAIL ulx_load_status got %0d want 0", bus.load_status); end
    tick();
    n_vec++; if (bus.load_status !== 3'd1) begin n_err++; $display("FAIL ulz_load_status got %0d want 1", bus.load_status); end
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL ulz_res_valid got %b want 0", bus.res_valid); end
    tick();
    core_done = 1'b0;
    bus.becStatus = 4'b1000;
    n_vec++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL ul_res_valid got %b want 1", bus.res_valid); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ul_busy got %b want 0", bus.busy); end
    for (int r = 0; r < 16; r++) begin
      case (r)
        0, 1, 2, 3, 4:      exp_w = 32'h5555_5555;
        5:                  exp_w = 32'h0000_0005;
        8, 9, 10, 11, 12:   exp_w = 32'hAAAA_AAAA;
        13:                 exp_w = 32'h0000_0002;
        default:            exp_w = 32'h0;
      endcase
      bus.rd_sel = 4'(r);
      #1;
      n_vec++; if (bus.rd_data !== exp_w) begin n_err++; $display("FAIL rd_sel%0d got %h want %h", r, bus.rd_data, exp_w); end
      $display("read rd_sel %0d data %08h", r, bus.rd_data);
    end
    bus.rd_sel = 4'd0;
    write_word(3'd0, 3'd0, 32'h1234_5678);
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL wr_clears_res_valid got %b want 0", bus.res_valid); end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL flags_cleared_err got %b want 1", bus.err); end
  endtask

  task automatic test_key_stream();
    clear_pat();
    pat[6][0] = 32'h0000_0001;
    pat[6][5] = 32'h0000_0004;
    load_slots(0, 6);
    drive_to_run();
    for (int k = 0; k < 163; k++) begin
      n_vec++; if (bus.ki !== ((k == 0) || (k == 162))) begin n_err++; $display("FAIL ki_bit%0d got %b want %b", k, bus.ki, ((k == 0) || (k == 162))); end
      $display("key bit %0d ki %b", k, bus.ki);
      bus.next_key = 1'b1;
      tick();
      bus.next_key = 1'b0;
    end
    n_vec++; if (bus.ki !== 1'b0) begin n_err++; $display("FAIL ki_drained got %b want 0", bus.ki); end
    finish_run();
  endtask

  task automatic test_top_word();
    clear_pat();
    pat[0][5] = 32'hFFFF_FFFF;
    pat[6][5] = 32'h0000_0004;
    load_slots(0, 6);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.becStatus = 4'b0100;
    tick();
    tick();
    exp_v = {3'b111, 160'h0};
    n_vec++; if (bus.data_in !== exp_v) begin n_err++; $display("FAIL top_word_data_in got %h want %h", bus.data_in, exp_v); end
    $display("top word beat data_in %h", bus.data_in);
    repeat (6) tick();
    bus.becStatus = 4'b0010;
    tick();
  endtask

  task automatic test_reset_mid_run();
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mid_run_busy got %b want 1", bus.busy); end
    #3;
    rst = 1'b1;
    #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.ki !== 1'b0) begin n_err++; $display("FAIL arst_ki got %b want 0", bus.ki); end
    n_vec++; if (bus.load_data !== 1'b0) begin n_err++; $display("FAIL arst_load_data got %b want 0", bus.load_data); end
    n_vec++; if (bus.enable !== 1'b0) begin n_err++; $display("FAIL arst_enable got %b want 0", bus.enable); end
    n_vec++; if (bus.trigLoad !== 1'b0) begin n_err++; $display("FAIL arst_trigLoad got %b want 0", bus.trigLoad); end
    n_vec++; if (bus.load_status !== 3'd0) begin n_err++; $display("FAIL arst_load_status got %0d want 0", bus.load_status); end
    n_vec++; if (bus.data_in !== '0) begin n_err++; $display("FAIL arst_data_in got %h want 0", bus.data_in); end
    n_vec++; if (bus.rd_data !== '0) begin n_err++; $display("FAIL arst_rd_data got %h want 0", bus.rd_data); end
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL arst_res_valid got %b want 0", bus.res_valid); end
    bus.becStatus = 4'b1000;
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_vec++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL arst_wr_ready got %b want 1", bus.wr_ready); end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL arst_restart_err got %b want 1", bus.err); end
    n_vec++; if (bus.load_data !== 1'b0) begin n_err++; $display("FAIL arst_restart_load_data got %b want 0", bus.load_data); end
    $display("reset mid-run checked");
  endtask

  initial begin
    test_reset();
    test_err_missing_key();
    test_download();
    test_unload();
    test_key_stream();
    test_top_word();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
